// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous block RAM between two
// requesters. At most one access is granted per cycle, the RAM command pins
// are driven straight from the winning port, and read data is handed back
// to whichever port issued the read.
module ram_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 16,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_ce,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // Port that won the most recent grant (0 or 1)
  logic       last_gnt;
  // Cycles port 1 has been kept waiting, saturating at 15
  logic [3:0] wait_cnt;
  // A read was presented to the RAM last cycle, and which port issued it
  logic       rd_pend;
  logic       rd_tag;
  // Tie-break decision: 1 when port 1 should win a simultaneous request
  logic       pick1;

  // Tie-break: round-robin alternates away from the last winner; fixed mode
  // favours port 0 until port 1 has waited long enough
  always_comb begin
    pick1 = 1'b0;
    if (FIXED_PRIO != 0) begin
      pick1 = (wait_cnt >= WAIT_LIMIT);
    end else begin
      pick1 = ~last_gnt;
    end
  end

  // Grant generation: a lone requester always wins, ties use pick1
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = ~pick1;
      gnt1 = pick1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // RAM command mux: pass the winning port through, idle to zero otherwise
  always_comb begin
    ram_ce  = gnt0 | gnt1;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (gnt0) begin
      ram_wre = we0;
      ram_ad  = addr0;
      ram_din = wdata0;
    end else if (gnt1) begin
      ram_wre = we1;
      ram_ad  = addr1;
      ram_din = wdata1;
    end
  end

  // Arbitration history: last winner and port-1 starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      wait_cnt <= 4'd0;
    end else begin
      if (gnt0 || gnt1) begin
        last_gnt <= gnt1;
      end
      if (gnt1 || !req1) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Read pipeline: remember a read issued this cycle so its data, which the
  // RAM returns one cycle later, can be tagged to the right port; reset
  // discards any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= ram_ce & ~ram_wre;
      if (ram_ce && !ram_wre) begin
        rd_tag <= gnt1;
      end
    end
  end

  assign rvalid0 = rd_pend & ~rd_tag;
  assign rvalid1 = rd_pend & rd_tag;
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;

endmodule
